demux1_2_stream: RTL and testbench
==================================

Name: demux1_2_stream

Overview:
- 1-to-2 stream demultiplexer with a valid/ready handshake on every interface.
- Steers each input beat to output 0 or output 1 according to in_sel.
- Packet-aware: the destination is locked from the first beat of a packet until its last beat.
- Each output is a registered one-entry stage; it sits in the datapath wherever one producer must feed two consumers, which is the dual of the 2:1 selection mux.

Parameters:
WIDTH, 8, data bits per beat

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_data  input  WIDTH  input beat payload
in_sel  input  1  destination (0 = out0, 1 = out1); sampled only on first beat of a packet
in_last  input  1  marks final beat of packet
in_valid  input  1  input beat present
in_ready  output  1  block accepts beat this cycle
out0_data  output  WIDTH  output 0 payload
out0_last  output  1  output 0 last marker
out0_valid  output  1  output 0 beat present
out0_ready  input  1  downstream 0 accepts
out1_data  output  WIDTH  output 1 payload
out1_last  output  1  output 1 last marker
out1_valid  output  1  output 1 beat present
out1_ready  input  1  downstream 1 accepts

Behaviour:
- Reset (rst_n low at a clk edge):
  - outN_valid=0, outN_data=0, outN_last=0.
  - FSM returns to IDLE; lock_sel=0.
  - in_ready is forced 0 while rst_n is low.
- Reset mid-packet discards both the lock and any buffered beats; there is no partial-packet recovery.
- Transfer occurs on any interface when valid and ready are both 1 at a rising edge.
- Effective select:
  - eff_sel = in_sel in IDLE.
  - eff_sel = lock_sel in LOCK.
- in_ready is combinational: rst_n & (~outS_valid | outS_ready), where S = eff_sel. It must not depend on in_valid.
- Accepted beat: loaded into output S register at that edge. outS_valid rises the next cycle, giving 1-cycle latency.
- Output register per channel:
  - Load on accept (valid set).
  - Else clear valid on outN_valid & outN_ready.
  - Simultaneous drain and load in the same cycle keeps valid=1 with the new data, so one output sustains 1 beat/clk.
- While outN_valid=1 and outN_ready=0, outN_data and outN_last hold stable.
- The non-selected output drains independently; a stalled output never blocks traffic to the other output once the lock releases.
- FSM, two states:
  - IDLE: accept with in_last=0 -> LOCK, lock_sel<=in_sel. Accept with in_last=1 -> stay IDLE (single-beat packet).
  - LOCK: in_sel is ignored. Accept with in_last=1 -> IDLE. Otherwise stay LOCK.
- No accept -> state unchanged.
- Upstream obligation: in_data, in_sel and in_last stay stable while in_valid=1 and in_ready=0. The bench asserts this and the RTL does not check it.
- No beat is dropped or duplicated. Beat order is preserved per output.

Decomposition:
- Shared package/include holds:
  - SEL_OUT0=1'b0, SEL_OUT1=1'b1.
  - State encoding ST_IDLE=1'b0, ST_LOCK=1'b1.
- One sub-module, stream_reg1: one-entry registered stage with WIDTH+1 payload (data+last), valid/ready, and synchronous active-low reset. Instantiated twice, once per output.
- The top level contains the FSM, lock register, eff_sel decode and in_ready logic.

Test Plan:
- Reset: hold rst_n=0 for 3 clks with in_valid=1 -> in_ready=0, out0_valid=out1_valid=0, data=0. Release -> first beat accepted on the next edge.
- Single-beat routing: beat 0xA5, sel=1, last=1 -> out1_valid=1, out1_data=0xA5 one cycle later; out0_valid stays 0; FSM stays IDLE.
- Packet lock: 4-beat packet 0x01..0x04, sel=0 on beat 1, in_sel toggled on beats 2-4 -> all four beats appear on out0 in order, out1_valid never set, FSM back in IDLE after beat 0x04.
- Backpressure: out0_ready=0 with a 3-beat packet to out0 -> in_ready=0 after the first beat and out0_data holds 0x01. Raise out0_ready -> 0x02 and 0x03 follow at 1 beat/clk, no loss.
- Independent drain: out1 holds 0x77 with out1_ready=0, next packet sel=0 -> out0 packet flows at full rate while out1_data stays 0x77.
- Mid-packet reset: assert rst_n=0 after 2 of 4 beats -> both valids clear, FSM IDLE. Next packet with sel=1 routes to out1.

Source files
------------

// File: rtl/demux1_2_stream_pkg.sv
// Shared select and FSM encodings for the 1:2 packet-aware stream demux.
package demux1_2_stream_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/demux1_2_stream_if.sv
// Bundle of the input stream and both output streams of the 1:2 demux.
interface demux1_2_stream_if #(
  parameter int unsigned WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_last;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_last;
  logic             out1_valid;
  logic             out1_ready;

  // Environment side: upstream producer plus both downstream consumers.
  modport master (
    output in_data, in_sel, in_last, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid
  );

  // Demux side.
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_last, out0_valid,
           out1_data, out1_last, out1_valid
  );

endinterface

// File: rtl/demux1_2_stream_stream_reg1.sv
// One-entry registered stream stage; a drain and a load in the same cycle
// keep the stage full so it sustains one beat per clock.
module stream_reg1 #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready_c,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;
  logic         load;

  assign in_ready_c = ~valid_q | out_ready;
  assign load       = in_valid & in_ready_c;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (load) begin
      valid_d   = 1'b1;
      payload_d = in_payload;
    end else if (valid_q && out_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/demux1_2_stream.sv
// 1:2 stream demux: routes each packet to out0/out1 by in_sel sampled on the
// first beat, holding the destination until the last beat is accepted.
module demux1_2_stream
  import demux1_2_stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  demux1_2_stream_if.slave bus
);

  localparam int unsigned PW = WIDTH + 1;

  state_e          state_q, state_d;
  logic            lock_sel_q, lock_sel_d;
  logic            eff_sel;
  logic            accept;
  logic            load0, load1;
  logic            rdy0_c, rdy1_c;
  logic            vld0, vld1;
  logic [PW-1:0]   pay_in;
  logic [PW-1:0]   pay0, pay1;

  assign eff_sel      = (state_q == ST_LOCK) ? lock_sel_q : bus.in_sel;
  assign bus.in_ready = rst_n & ((eff_sel == SEL_OUT1) ? rdy1_c : rdy0_c);
  assign accept       = bus.in_valid & bus.in_ready;
  assign load0        = accept & (eff_sel == SEL_OUT0);
  assign load1        = accept & (eff_sel == SEL_OUT1);
  assign pay_in       = {bus.in_last, bus.in_data};

  // Destination lock: opens on a non-last first beat, closes on the last beat.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!bus.in_last) begin
            state_d    = ST_LOCK;
            lock_sel_d = bus.in_sel;
          end
        end
        ST_LOCK: begin
          if (bus.in_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= SEL_OUT0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  stream_reg1 #(.W(PW)) u_out0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (load0),
    .in_ready_c  (rdy0_c),
    .in_payload  (pay_in),
    .out_valid   (vld0),
    .out_ready   (bus.out0_ready),
    .out_payload (pay0)
  );

  stream_reg1 #(.W(PW)) u_out1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (load1),
    .in_ready_c  (rdy1_c),
    .in_payload  (pay_in),
    .out_valid   (vld1),
    .out_ready   (bus.out1_ready),
    .out_payload (pay1)
  );

  assign bus.out0_valid = vld0;
  assign bus.out0_last  = pay0[PW-1];
  assign bus.out0_data  = pay0[WIDTH-1:0];
  assign bus.out1_valid = vld1;
  assign bus.out1_last  = pay1[PW-1];
  assign bus.out1_data  = pay1[WIDTH-1:0];

endmodule

// File: tb/tb_demux1_2_stream.sv
// Directed, table-driven bench for demux1_2_stream plus hand-written
// sequences for the multi-cycle corner cases.
module tb_demux1_2_stream;

  logic clk;
  logic rst_n;

  demux1_2_stream_if #(.WIDTH(8)) bus ();

  demux1_2_stream #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       l;
    logic       r0;
    logic       r1;
    logic       er;
    logic       e0v;
    logic [7:0] e0d;
    logic       e0l;
    logic       e1v;
    logic [7:0] e1d;
    logic       e1l;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_err = 0;

  logic       prev_stall = 1'b0;
  logic [7:0] prev_d;
  logic       prev_s;
  logic       prev_l;

  function automatic vec_t mk(
    input logic rst, input logic v, input logic [7:0] d, input logic s,
    input logic l, input logic r0, input logic r1, input logic er,
    input logic e0v, input logic [7:0] e0d, input logic e0l,
    input logic e1v, input logic [7:0] e1d, input logic e1l);
    vec_t t;
    t.rst_n = rst; t.v = v; t.d = d; t.s = s; t.l = l; t.r0 = r0; t.r1 = r1;
    t.er = er; t.e0v = e0v; t.e0d = e0d; t.e0l = e0l;
    t.e1v = e1v; t.e1d = e1d; t.e1l = e1l;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [7:0] d,
                       input logic s, input logic l, input logic r0, input logic r1);
    rst_n          = rst;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_sel     = s;
    bus.in_last    = l;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data/last are compared whenever the output holds a beat, and under reset.
  task automatic chk_outs(input string tag, input logic force_data,
                          input logic e0v, input logic [7:0] e0d, input logic e0l,
                          input logic e1v, input logic [7:0] e1d, input logic e1l);
    chk({tag, " out0_valid"}, 8'(bus.out0_valid), 8'(e0v));
    chk({tag, " out1_valid"}, 8'(bus.out1_valid), 8'(e1v));
    if (e0v || force_data) begin
      chk({tag, " out0_data"}, bus.out0_data, e0d);
      chk({tag, " out0_last"}, 8'(bus.out0_last), 8'(e0l));
    end
    if (e1v || force_data) begin
      chk({tag, " out1_data"}, bus.out1_data, e1d);
      chk({tag, " out1_last"}, 8'(bus.out1_last), 8'(e1l));
    end
  endtask

  // Upstream must hold its beat steady while stalled.
  task automatic stab_check(input string tag);
    if (prev_stall) begin
      chk({tag, " hold in_valid"}, 8'(bus.in_valid), 8'h01);
      chk({tag, " hold in_data"}, bus.in_data, prev_d);
      chk({tag, " hold in_sel"}, 8'(bus.in_sel), 8'(prev_s));
      chk({tag, " hold in_last"}, 8'(bus.in_last), 8'(prev_l));
    end
    prev_stall = rst_n & bus.in_valid & ~bus.in_ready;
    prev_d     = bus.in_data;
    prev_s     = bus.in_sel;
    prev_l     = bus.in_last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              rst v  d     s  l  r0 r1 | er e0v e0d  e0l e1v e1d  e1l
    // Reset held with in_valid high, then release and accept on the next edge.
    vecs[0]  = mk(0, 1, 8'h11, 0, 1, 1, 1,   0, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[1]  = mk(0, 1, 8'h11, 0, 1, 1, 1,   0, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[2]  = mk(0, 1, 8'h11, 0, 1, 1, 1,   0, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[3]  = mk(1, 1, 8'h11, 0, 1, 1, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0);
    // Single-beat packet to out1.
    vecs[4]  = mk(1, 1, 8'hA5, 1, 1, 1, 1,   1, 1, 8'h11, 1, 0, 8'h00, 0);
    // 4-beat packet locked to out0 while in_sel toggles.
    vecs[5]  = mk(1, 1, 8'h01, 0, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'hA5, 1);
    vecs[6]  = mk(1, 1, 8'h02, 1, 0, 1, 1,   1, 1, 8'h01, 0, 0, 8'h00, 0);
    vecs[7]  = mk(1, 1, 8'h03, 1, 0, 1, 1,   1, 1, 8'h02, 0, 0, 8'h00, 0);
    vecs[8]  = mk(1, 1, 8'h04, 0, 1, 1, 1,   1, 1, 8'h03, 0, 0, 8'h00, 0);
    // Back in IDLE: sel=1 sees the empty out1 even though out0 is stalled.
    vecs[9]  = mk(1, 1, 8'h21, 1, 1, 0, 1,   1, 1, 8'h04, 1, 0, 8'h00, 0);
    vecs[10] = mk(1, 0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h04, 1, 1, 8'h21, 1);
    // Backpressure on out0 during a 3-beat packet.
    vecs[11] = mk(1, 1, 8'h01, 0, 0, 0, 1,   1, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[12] = mk(1, 1, 8'h02, 0, 0, 0, 1,   0, 1, 8'h01, 0, 0, 8'h00, 0);
    vecs[13] = mk(1, 1, 8'h02, 0, 0, 0, 1,   0, 1, 8'h01, 0, 0, 8'h00, 0);
    vecs[14] = mk(1, 1, 8'h02, 0, 0, 1, 1,   1, 1, 8'h01, 0, 0, 8'h00, 0);
    vecs[15] = mk(1, 1, 8'h03, 0, 1, 1, 1,   1, 1, 8'h02, 0, 0, 8'h00, 0);
    vecs[16] = mk(1, 0, 8'h00, 0, 0, 1, 1,   1, 1, 8'h03, 1, 0, 8'h00, 0);
    // out1 stalled with 0x77 while a packet streams to out0 at full rate.
    vecs[17] = mk(1, 1, 8'h77, 1, 1, 1, 0,   1, 0, 8'h00, 0, 0, 8'h00, 0);
    vecs[18] = mk(1, 1, 8'h31, 0, 0, 1, 0,   1, 0, 8'h00, 0, 1, 8'h77, 1);
    vecs[19] = mk(1, 1, 8'h32, 1, 0, 1, 0,   1, 1, 8'h31, 0, 1, 8'h77, 1);
    vecs[20] = mk(1, 1, 8'h33, 1, 1, 1, 0,   1, 1, 8'h32, 0, 1, 8'h77, 1);
    // Beat for the stalled out1 waits, then drains and loads in one cycle.
    vecs[21] = mk(1, 1, 8'h41, 1, 1, 1, 0,   0, 1, 8'h33, 1, 1, 8'h77, 1);
    vecs[22] = mk(1, 1, 8'h41, 1, 1, 1, 1,   1, 0, 8'h00, 0, 1, 8'h77, 1);
    vecs[23] = mk(1, 0, 8'h00, 0, 0, 1, 1,   1, 0, 8'h00, 0, 1, 8'h41, 1);

    drive(0, 1, 8'h11, 0, 1, 1, 1);
    step();

    for (int i = 0; i < NVEC; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].rst_n, vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].l,
            vecs[i].r0, vecs[i].r1);
      #1;
      stab_check(tag);
      chk({tag, " in_ready"}, 8'(bus.in_ready), 8'(vecs[i].er));
      chk_outs(tag, ~vecs[i].rst_n, vecs[i].e0v, vecs[i].e0d, vecs[i].e0l,
               vecs[i].e1v, vecs[i].e1d, vecs[i].e1l);
      step();
    end

    // Mid-packet reset: two beats to out0, then reset discards lock and data.
    drive(1, 1, 8'h51, 0, 0, 0, 1);
    #1;
    chk("mrst beat1 in_ready", 8'(bus.in_ready), 8'h01);
    step();
    drive(1, 1, 8'h52, 0, 0, 1, 1);
    #1;
    chk("mrst beat2 in_ready", 8'(bus.in_ready), 8'h01);
    chk_outs("mrst beat2", 1'b0, 1, 8'h51, 0, 0, 8'h00, 0);
    step();
    drive(0, 1, 8'h53, 0, 0, 0, 1);
    #1;
    chk("mrst in_ready forced low", 8'(bus.in_ready), 8'h00);
    step();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    #1;
    chk_outs("mrst after reset", 1'b1, 0, 8'h00, 0, 0, 8'h00, 0);
    step();

    // New single-beat packet to out1 must route there (lock was cleared).
    drive(1, 1, 8'h61, 1, 1, 0, 0);
    begin
      bit got = 1'b0;
      for (int c = 0; c < 8; c++) begin
        #1;
        if (bus.in_ready) begin
          got = 1'b1;
          break;
        end
        step();
      end
      chk("mrst wait in_ready", 8'(got), 8'h01);
    end
    step();
    drive(1, 0, 8'h00, 0, 0, 0, 0);
    #1;
    chk_outs("mrst new packet", 1'b0, 0, 8'h00, 0, 1, 8'h61, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
